// File: rtl/reset_teardown_seq.sv
// Run-time soft-reset sequencer: drains and asserts the staged domain resets
// in order 2,1,0, holds them all, then releases them in order 0,1,2.
module reset_teardown_seq #(
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 1024,
    parameter int GAP     = 16,
    parameter int HOLD    = 256
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iREQ,
    input  logic [2:0] iQUIET,
    output logic       oRST_0,
    output logic       oRST_1,
    output logic       oRST_2,
    output logic [2:0] oDRAIN,
    output logic [2:0] oTO_FLAG,
    output logic       oBUSY,
    output logic       oDONE,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_DRAIN2 = 4'd1,
        S_GAP2   = 4'd2,
        S_DRAIN1 = 4'd3,
        S_GAP1   = 4'd4,
        S_DRAIN0 = 4'd5,
        S_GAP0   = 4'd6,
        S_HOLD   = 4'd7,
        S_REL1   = 4'd8,
        S_REL2   = 4'd9
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       rst_q, rst_d;
    logic [2:0]       drain_q, drain_d;
    logic [2:0]       to_q, to_d;
    logic             done_q, done_d;

    logic to_end, gap_end, hold_end;

    assign to_end   = (cnt_q == TO_LAST);
    assign gap_end  = (cnt_q == GAP_LAST);
    assign hold_end = (cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        rst_d   = rst_q;
        drain_d = drain_q;
        to_d    = to_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iREQ) begin
                    state_d = S_DRAIN2;
                    drain_d = 3'b100;
                    to_d    = 3'b000;
                end
            end
            // Quiet has priority over a simultaneous timeout, so the flag only
            // records stages that really had to be forced.
            S_DRAIN2: begin
                if (iQUIET[2] || to_end) begin
                    to_d[2]  = to_q[2] | ~iQUIET[2];
                    rst_d[2] = 1'b0;
                    drain_d  = 3'b000;
                    state_d  = S_GAP2;
                end
            end
            S_GAP2: begin
                if (gap_end) begin
                    drain_d = 3'b010;
                    state_d = S_DRAIN1;
                end
            end
            S_DRAIN1: begin
                if (iQUIET[1] || to_end) begin
                    to_d[1]  = to_q[1] | ~iQUIET[1];
                    rst_d[1] = 1'b0;
                    drain_d  = 3'b000;
                    state_d  = S_GAP1;
                end
            end
            S_GAP1: begin
                if (gap_end) begin
                    drain_d = 3'b001;
                    state_d = S_DRAIN0;
                end
            end
            S_DRAIN0: begin
                if (iQUIET[0] || to_end) begin
                    to_d[0]  = to_q[0] | ~iQUIET[0];
                    rst_d[0] = 1'b0;
                    drain_d  = 3'b000;
                    state_d  = S_GAP0;
                end
            end
            S_GAP0: begin
                if (gap_end) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (hold_end) begin
                    rst_d[0] = 1'b1;
                    state_d  = S_REL1;
                end
            end
            S_REL1: begin
                if (gap_end) begin
                    rst_d[1] = 1'b1;
                    state_d  = S_REL2;
                end
            end
            S_REL2: begin
                if (gap_end) begin
                    rst_d[2] = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    // Every state entry restarts the shared wait counter; IDLE keeps it parked.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            rst_q   <= 3'b000;
            drain_q <= 3'b000;
            to_q    <= 3'b000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            drain_q <= drain_d;
            to_q    <= to_d;
            done_q  <= done_d;
        end
    end

    assign oRST_0    = rst_q[0];
    assign oRST_1    = rst_q[1];
    assign oRST_2    = rst_q[2];
    assign oDRAIN    = drain_q;
    assign oTO_FLAG  = to_q;
    assign oDONE     = done_q;
    assign oBUSY     = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule
